// File: rtl/ts_rate_adapter_pkg.sv
// ts_rate_adapter_pkg
// Shared constants and types for the TS rate adapter:
//   TS_SYNC      - MPEG-TS sync byte (0x47)
//   NULL_PID     - PID carried by inserted null packets (0x1FFF)
//   PKT_LEN_DEF  - default TS packet length in bytes (188)
//   rd_state_t   - read-side packet state (IDLE / DATA / NULLPKT)
//   null_byte()  - byte at a given index of an inserted null packet
package ts_rate_adapter_pkg;

  localparam logic [7:0]  TS_SYNC     = 8'h47;
  localparam logic [12:0] NULL_PID    = 13'h1FFF;
  localparam int          PKT_LEN_DEF = 188;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_DATA = 2'd1,
    RD_NULL = 2'd2
  } rd_state_t;

  // Null packet header: sync, PUSI=0/PID[12:8], PID[7:0], payload-only with
  // CC=0; the payload is all 0xFF stuffing.
  function automatic logic [7:0] null_byte(input int unsigned idx);
    logic [7:0] b;
    case (idx)
      0:       b = TS_SYNC;
      1:       b = {3'b000, NULL_PID[12:8]};
      2:       b = NULL_PID[7:0];
      3:       b = 8'h10;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ts_byte_fifo.sv
// ts_byte_fifo
// Simple dual-port byte RAM used as FIFO storage. Pointer management and
// full/empty tracking live in the parent; this block only stores bytes.
// Ports:
//   CLK      in   clock, rising edge
//   i_we     in   write enable
//   i_waddr  in   write address [AW-1:0]
//   i_wdata  in   write byte
//   i_re     in   read enable
//   i_raddr  in   read address [AW-1:0]
//   o_rdata  out  read byte, valid the cycle after i_re
module ts_byte_fifo #(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_rdata;

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ts_rate_adapter.sv
// ts_rate_adapter
// Converts a bursty TS byte stream into a constant-rate stream. Complete
// input packets are buffered in a byte FIFO; the output side emits one byte
// per phase-accumulator tick, taking whole packets from the FIFO when one is
// available and otherwise inserting null packets (PID 0x1FFF).
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous reset, active-low
//   DATA_IN    in   [7:0] input TS byte
//   ENA_IN     in   DATA_IN valid
//   PSYNC_IN   in   first byte of an input packet
//   RATE_INC   in   [15:0] phase increment, byte rate = f_CLK*RATE_INC/65536
//   DATA_OUT   out  [7:0] output TS byte
//   ENA_OUT    out  DATA_OUT valid
//   PSYNC_OUT  out  first byte of an output packet
//   NULL_OUT   out  byte belongs to an inserted null packet
//   OVF_PULSE  out  input packet dropped for lack of FIFO space
//   DROP_CNT   out  [15:0] malformed input packets dropped (saturating)
//   UNF_CNT    out  [15:0] null packets inserted (saturating)
// Build option: define SYNC_CHECK_EN to drop packets whose opening byte is
// not 0x47 or that are cut short by an early PSYNC_IN, counting them in
// DROP_CNT. Without it, an early PSYNC_IN silently restarts the packet and
// DROP_CNT stays 0.
module ts_rate_adapter
  import ts_rate_adapter_pkg::*;
#(
  parameter int FIFO_AW = 10,
  parameter int PKT_LEN = PKT_LEN_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        ENA_IN,
  input  logic        PSYNC_IN,
  input  logic [15:0] RATE_INC,
  output logic [7:0]  DATA_OUT,
  output logic        ENA_OUT,
  output logic        PSYNC_OUT,
  output logic        NULL_OUT,
  output logic        OVF_PULSE,
  output logic [15:0] DROP_CNT,
  output logic [15:0] UNF_CNT
);

  localparam int PW    = FIFO_AW + 1;
  localparam int CW    = $clog2(PKT_LEN + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  // Rate tick: carry-out of the 16-bit phase accumulator
  logic [15:0] r_phase;
  logic [16:0] w_phase_sum;
  logic        w_tick;

  assign w_phase_sum = {1'b0, r_phase} + {1'b0, RATE_INC};
  assign w_tick      = w_phase_sum[16];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_phase <= '0;
    else      r_phase <= w_phase_sum[15:0];
  end

  // Write side: packets are written speculatively from the commit pointer
  // and only become visible to the reader when their last byte arrives.
  logic [PW-1:0] r_wr_ptr, r_cm_ptr, r_rd_ptr, r_pkt_cnt;
  logic [CW-1:0] r_in_cnt;
  logic          r_open;   // a packet is in progress on the input
  logic          r_skip;   // in-progress packet is being discarded (no room)
  logic          r_ovf;

  logic [PW-1:0] w_used;
  logic          w_space_ok, w_open_req, w_bad_head, w_accept_open;
  logic          w_cont, w_last, w_commit, w_we;
  logic [PW-1:0] w_waddr;

  // Used space counts committed bytes only; the open packet always restarts
  // from the commit pointer, so its partial bytes never reduce free space.
  assign w_used     = r_cm_ptr - r_rd_ptr;
  assign w_space_ok = (32'(w_used) + 32'(PKT_LEN)) <= 32'(DEPTH);
  assign w_open_req = ENA_IN & PSYNC_IN;

`ifdef SYNC_CHECK_EN
  assign w_bad_head = w_open_req & w_space_ok & (DATA_IN != TS_SYNC);
`else
  assign w_bad_head = 1'b0;
`endif

  assign w_accept_open = w_open_req & w_space_ok & ~w_bad_head;
  assign w_cont        = ENA_IN & ~PSYNC_IN & r_open;
  assign w_last        = w_cont & (r_in_cnt == CW'(PKT_LEN - 1));
  assign w_commit      = w_last & ~r_skip;
  assign w_we          = w_accept_open | (w_cont & ~r_skip);
  assign w_waddr       = w_accept_open ? r_cm_ptr : r_wr_ptr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_in_cnt <= '0;
      r_open   <= 1'b0;
      r_skip   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_ovf <= w_open_req & ~w_space_ok;
      if (w_open_req) begin
        // Any PSYNC_IN abandons a partial packet by restarting at the commit
        // pointer; an over-full FIFO still tracks the packet to swallow it.
        r_open   <= ~w_bad_head;
        r_skip   <= ~w_space_ok;
        r_in_cnt <= CW'(1);
        r_wr_ptr <= w_accept_open ? r_cm_ptr + PW'(1) : r_cm_ptr;
      end else if (w_cont) begin
        if (w_last) begin
          r_open   <= 1'b0;
          r_skip   <= 1'b0;
          r_in_cnt <= '0;
        end else begin
          r_in_cnt <= r_in_cnt + CW'(1);
        end
        if (!r_skip) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_commit) r_cm_ptr <= r_wr_ptr + PW'(1);
      end
    end
  end

`ifdef SYNC_CHECK_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  // A packet already being swallowed for overflow is not counted again
  assign w_drop = w_bad_head | (w_open_req & r_open & ~r_skip);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                          r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  assign DROP_CNT = r_drop_cnt;
`else
  assign DROP_CNT = '0;
`endif

  // Read side: packet choice happens only on the tick that starts a packet
  rd_state_t     r_state, w_state_nxt, w_cur;
  logic [CW-1:0] r_idx, w_idx_nxt;
  logic          w_boundary, w_rd_en, w_first_rd, w_enter_null;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= RD_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cur        = r_state;
    w_rd_en      = 1'b0;
    w_first_rd   = 1'b0;
    w_enter_null = 1'b0;
    w_boundary   = (r_state == RD_IDLE) || (r_idx == '0);
    if (w_tick) begin
      if (w_boundary) w_cur = (r_pkt_cnt != '0) ? RD_DATA : RD_NULL;
      w_state_nxt  = w_cur;
      w_idx_nxt    = (r_idx == CW'(PKT_LEN - 1)) ? '0 : r_idx + CW'(1);
      w_rd_en      = (w_cur == RD_DATA);
      w_first_rd   = w_rd_en & w_boundary;
      w_enter_null = (w_cur == RD_NULL) & w_boundary;
    end
  end

  logic [15:0] r_unf_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd_ptr  <= '0;
      r_pkt_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      // Commit and first read in the same cycle cancel out
      case ({w_commit, w_first_rd})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PW'(1);
        default: ;
      endcase
      if (w_enter_null && r_unf_cnt != 16'hFFFF) r_unf_cnt <= r_unf_cnt + 16'd1;
    end
  end

  logic [7:0] w_rdata;

  ts_byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .CLK     (CLK),
    .i_we    (w_we),
    .i_waddr (w_waddr[FIFO_AW-1:0]),
    .i_wdata (DATA_IN),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[FIFO_AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Output stage: RAM read register and null-byte register are selected by
  // r_from_fifo, so every output is one register after the tick.
  logic       r_ena_out, r_psync_out, r_null_out, r_from_fifo;
  logic [7:0] r_null_byte;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ena_out   <= 1'b0;
      r_psync_out <= 1'b0;
      r_null_out  <= 1'b0;
      r_from_fifo <= 1'b0;
      r_null_byte <= '0;
    end else begin
      r_ena_out   <= w_tick;
      r_psync_out <= w_tick & (r_idx == '0);
      r_null_out  <= w_tick & (w_cur == RD_NULL);
      r_from_fifo <= w_rd_en;
      if (w_tick && w_cur == RD_NULL) r_null_byte <= null_byte(32'(r_idx));
    end
  end

  assign DATA_OUT  = r_from_fifo ? w_rdata : r_null_byte;
  assign ENA_OUT   = r_ena_out;
  assign PSYNC_OUT = r_psync_out;
  assign NULL_OUT  = r_null_out;
  assign OVF_PULSE = r_ovf;
  assign UNF_CNT   = r_unf_cnt;

endmodule

// File: tb/tb_ts_rate_adapter.sv
// tb_ts_rate_adapter
// Directed bench for ts_rate_adapter (FIFO_AW=10, PKT_LEN=188). Output bytes
// are collected by a monitor; each step compares them with expected streams
// built from the stimulus. Honours SYNC_CHECK_EN when it is defined.
module tb_ts_rate_adapter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  DATA_IN = '0;
  logic        ENA_IN = 1'b0;
  logic        PSYNC_IN = 1'b0;
  logic [15:0] RATE_INC = '0;
  logic [7:0]  DATA_OUT;
  logic        ENA_OUT, PSYNC_OUT, NULL_OUT, OVF_PULSE;
  logic [15:0] DROP_CNT, UNF_CNT;

  ts_rate_adapter #(.FIFO_AW(10), .PKT_LEN(188)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DATA_IN   (DATA_IN),
    .ENA_IN    (ENA_IN),
    .PSYNC_IN  (PSYNC_IN),
    .RATE_INC  (RATE_INC),
    .DATA_OUT  (DATA_OUT),
    .ENA_OUT   (ENA_OUT),
    .PSYNC_OUT (PSYNC_OUT),
    .NULL_OUT  (NULL_OUT),
    .OVF_PULSE (OVF_PULSE),
    .DROP_CNT  (DROP_CNT),
    .UNF_CNT   (UNF_CNT)
  );

  always #5 CLK = ~CLK;

`ifdef SYNC_CHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       ps;
    logic       nl;
  } ob_t;

  ob_t        q[$];
  logic [7:0] exp_q[$];
  int         ovf_seen = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always @(negedge CLK) begin
    if (RST && ENA_OUT) q.push_back('{DATA_OUT, PSYNC_OUT, NULL_OUT});
    if (RST && OVF_PULSE) ovf_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] pbyte(input int p, input int k);
    if (k == 0) return 8'h47;
    return 8'(p * 29 + k * 7 + 3);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic ps);
    DATA_IN  = d;
    ENA_IN   = 1'b1;
    PSYNC_IN = ps;
    step();
    ENA_IN   = 1'b0;
    PSYNC_IN = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int len, input logic [7:0] first, input bit rec);
    logic [7:0] d;
    for (int k = 0; k < len; k++) begin
      d = (k == 0) ? first : pbyte(p, k);
      drive(d, k == 0);
      if (rec) exp_q.push_back(d);
    end
  endtask

  task automatic do_reset();
    RST      = 1'b0;
    RATE_INC = '0;
    ENA_IN   = 1'b0;
    PSYNC_IN = 1'b0;
    repeat (3) step();
    RST = 1'b1;
    q.delete();
    exp_q.delete();
    ovf_seen = 0;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int c = 0;
    while (q.size() < n && c < budget) begin
      step();
      c++;
    end
    chk(tag, 32'(q.size() >= n), 32'd1);
  endtask

  // Compare the non-null output bytes with exp_q; packets start every 188
  task automatic check_data(input string tag);
    logic [7:0] got[$];
    logic       gps[$];
    int         bad_d = 0;
    int         bad_p = 0;
    int         n;
    foreach (q[i]) if (!q[i].nl) begin
      got.push_back(q[i].d);
      gps.push_back(q[i].ps);
    end
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (got[i] !== exp_q[i]) bad_d++;
      if (gps[i] !== (i % 188 == 0)) bad_p++;
    end
    chk({tag, "_bytes"}, 32'(bad_d), 32'd0);
    chk({tag, "_psync"}, 32'(bad_p), 32'd0);
  endtask

  int null_pkts;
  int e, consec, bad;
  logic prev;
  logic [7:0] nb;

  initial begin
    // Reset state
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_data",  32'(DATA_OUT),  32'h0);
    chk("rst_ena",   32'(ENA_OUT),   32'h0);
    chk("rst_psync", 32'(PSYNC_OUT), 32'h0);
    chk("rst_null",  32'(NULL_OUT),  32'h0);
    chk("rst_ovf",   32'(OVF_PULSE), 32'h0);
    chk("rst_unf",   32'(UNF_CNT),   32'h0);
    chk("rst_drop",  32'(DROP_CNT),  32'h0);

    // Idle input at half rate: continuous null packets, one-cycle latency
    do_reset();
    RATE_INC = 16'h8000;
    @(negedge CLK); chk("lat_c0_ena", 32'(ENA_OUT), 32'd0);
    @(negedge CLK); chk("lat_c1_ena", 32'(ENA_OUT), 32'd0);
    @(negedge CLK);
    chk("lat_c2_ena",   32'(ENA_OUT),   32'd1);
    chk("lat_c2_data",  32'(DATA_OUT),  32'h47);
    chk("lat_c2_psync", 32'(PSYNC_OUT), 32'd1);
    chk("lat_c2_null",  32'(NULL_OUT),  32'd1);
    chk("lat_c2_unf",   32'(UNF_CNT),   32'd1);
    @(negedge CLK); chk("lat_c3_ena", 32'(ENA_OUT), 32'd0);
    @(negedge CLK);
    chk("lat_c4_ena",  32'(ENA_OUT),  32'd1);
    chk("lat_c4_data", 32'(DATA_OUT), 32'h1F);
    e = 0; consec = 0; prev = ENA_OUT;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (ENA_OUT) e++;
      if (ENA_OUT && prev) consec++;
      prev = ENA_OUT;
    end
    chk("half_rate_count",  32'(e), 32'd50);
    chk("half_rate_consec", 32'(consec), 32'd0);
    wait_bytes("null_wait", 400, 1000);
    bad = 0;
    for (int i = 0; i < 400 && i < q.size(); i++) begin
      case (i % 188)
        0:       nb = 8'h47;
        1:       nb = 8'h1F;
        2:       nb = 8'hFF;
        3:       nb = 8'h10;
        default: nb = 8'hFF;
      endcase
      if (q[i].d !== nb || q[i].ps !== (i % 188 == 0) || q[i].nl !== 1'b1) bad++;
    end
    chk("null_pattern", 32'(bad), 32'd0);
    @(negedge CLK); #1;
    chk("null_unf", 32'(UNF_CNT), 32'((q.size() + 187) / 188));
    RATE_INC = 16'h0;
    repeat (3) step();
    e = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (ENA_OUT) e++;
    end
    chk("rate0_no_ena", 32'(e), 32'd0);

    // Three back-to-back packets at full input rate, quarter output rate;
    // stray bytes before the first PSYNC_IN must vanish
    do_reset();
    RATE_INC = 16'h4000;
    drive(8'h11, 1'b0);
    drive(8'h22, 1'b0);
    drive(8'h33, 1'b0);
    for (int p = 0; p < 3; p++) send_pkt(p, 188, 8'h47, 1'b1);
    wait_bytes("b2b_wait", 800, 4000);
    @(negedge CLK); #1;
    check_data("b2b");
    null_pkts = 0;
    foreach (q[i]) if (q[i].nl && q[i].ps) null_pkts++;
    chk("b2b_unf", 32'(UNF_CNT), 32'(null_pkts));
    chk("b2b_ovf", 32'(ovf_seen), 32'd0);

    // Overflow: five packets fill the FIFO, the sixth is dropped
    do_reset();
    for (int p = 10; p < 15; p++) send_pkt(p, 188, 8'h47, 1'b1);
    chk("ovf_before", 32'(ovf_seen), 32'd0);
    send_pkt(15, 188, 8'h47, 1'b0);
    step();
    chk("ovf_once", 32'(ovf_seen), 32'd1);
    RATE_INC = 16'h8000;
    wait_bytes("ovf_wait", 1000, 2500);
    check_data("ovf");

    // Bad sync byte, then a packet cut short at byte 100 by a good packet
    do_reset();
    send_pkt(20, 188, 8'h48, !SC);
    send_pkt(21, 100, 8'h47, 1'b0);
    send_pkt(22, 188, 8'h47, 1'b1);
    step();
    chk("sync_drop_cnt", 32'(DROP_CNT), SC ? 32'd2 : 32'd0);
    RATE_INC = 16'h8000;
    wait_bytes("sync_wait", 400, 1200);
    check_data("sync");

    // Reset in the middle of an output data packet
    do_reset();
    send_pkt(30, 188, 8'h47, 1'b1);
    RATE_INC = 16'h8000;
    wait_bytes("mid_wait", 91, 400);
    chk("mid_byte90", 32'(q.size() > 90 ? {q[90].nl, q[90].d} : 9'h1FF), 32'({1'b0, exp_q[90]}));
    RST = 1'b0;
    #1;
    chk("mid_rst_data",  32'(DATA_OUT),  32'h0);
    chk("mid_rst_flags", 32'({ENA_OUT, PSYNC_OUT, NULL_OUT, OVF_PULSE}), 32'h0);
    step();
    chk("mid_rst_next",  32'({DATA_OUT, ENA_OUT, PSYNC_OUT, NULL_OUT, OVF_PULSE}), 32'h0);
    chk("mid_rst_unf",   32'(UNF_CNT), 32'h0);
    q.delete();
    RST = 1'b1;
    wait_bytes("post_wait", 1, 20);
    chk("post_first", 32'(q.size() > 0 ? {q[0].d, q[0].ps, q[0].nl} : 10'h0), 32'({8'h47, 1'b1, 1'b1}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ts_rate_adapter.md
TS_RATE_ADAPTER -- requirements
Module: ts_rate_adapter

Interface
REQ-001 SHALL have parameter FIFO_AW, default 10, meaning byte FIFO address width (depth 2^FIFO_AW = 1024 bytes).
REQ-002 SHALL have parameter PKT_LEN, default 188, meaning TS packet length in bytes.
REQ-003 CLK  in  1  system clock; all logic on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 DATA_IN  in  8  TS byte from the T2-MI packetiser.
REQ-006 ENA_IN  in  1  DATA_IN valid strobe.
REQ-007 PSYNC_IN  in  1  high with the first byte (0x47) of each packet.
REQ-008 RATE_INC  in  16  phase increment; output byte rate = f_CLK*RATE_INC/65536.
REQ-009 DATA_OUT  out  8  constant-rate TS byte.
REQ-010 ENA_OUT  out  1  DATA_OUT valid, one cycle per rate tick.
REQ-011 PSYNC_OUT  out  1  high with the first byte of each output packet.
REQ-012 NULL_OUT  out  1  high for every byte of an inserted null packet.
REQ-013 OVF_PULSE  out  1  one-cycle pulse when an input packet is dropped for lack of space.
REQ-014 DROP_CNT  out  16  count of input packets discarded as malformed, saturating.
REQ-015 UNF_CNT  out  16  count of inserted null packets, saturating at 0xFFFF.

Function
REQ-016 Phase accumulator: 16-bit add of RATE_INC each cycle; carry-out = tick; RATE_INC=0 -> no ticks, no output.
REQ-017 Write side: byte with ENA_IN&PSYNC_IN opens a packet at the current commit pointer; each ENA_IN byte is written at the write pointer and the in-packet count is incremented.
REQ-018 The PKT_LEN-th byte commits the packet: the commit pointer becomes the write pointer and the complete-packet count is incremented.
REQ-019 If free space (relative to the read pointer) is < PKT_LEN when a packet opens, the whole packet is discarded, OVF_PULSE fires once, and FIFO content is unchanged.
REQ-020 ENA_IN bytes arriving with no open packet (no preceding PSYNC_IN) are discarded silently.
REQ-021 Read side state machine: IDLE, DATA, NULLPKT; transitions are evaluated only on a tick.
REQ-022 IDLE or end of packet, on a tick: if complete-packet count > 0 -> DATA, else -> NULLPKT; UNF_CNT increments on entering NULLPKT.
REQ-023 DATA emits PKT_LEN FIFO bytes, one per tick; the first byte decrements the complete-packet count.
REQ-024 NULLPKT emits 0x47,0x1F,0xFF,0x10, then 184 bytes of 0xFF; NULL_OUT is high for all 188 bytes.
REQ-025 An output packet is never interrupted; packet choice is made only at boundaries.
REQ-026 Latency: tick in cycle N -> ENA_OUT/DATA_OUT/PSYNC_OUT valid in cycle N+1, registered.
REQ-027 Simultaneous commit and read-start in one cycle leave the complete-packet count unchanged.
REQ-028 Pointers wrap modulo 2^FIFO_AW; full and empty are distinguished by an extra MSB.

Reset
REQ-029 RST low: all pointers, counts, accumulator, and counters = 0; state=IDLE; DATA_OUT=0; ENA_OUT, PSYNC_OUT, NULL_OUT, OVF_PULSE = 0.
REQ-030 Reset mid-packet discards all buffered and partial data; the first output after release is a complete packet.

Configuration
REQ-031 Macro SYNC_CHECK_EN defined: an opening byte != 0x47, or a PSYNC_IN before byte PKT_LEN, drops the open packet (write pointer rewound to the commit pointer) and increments DROP_CNT; an early PSYNC_IN also opens a new packet.
REQ-032 Macro SYNC_CHECK_EN undefined: no content checks; an early PSYNC_IN rewinds and reopens without counting; DROP_CNT is tied to 0.

Structure
REQ-033 Shared package holds TS_SYNC=0x47, NULL_PID=0x1FFF, PKT_LEN default, and the read-state enum.
REQ-034 Byte storage is one sub-module ts_byte_fifo: simple dual-port RAM, 1-cycle read latency, no internal flags.

Verification
REQ-035 RATE_INC=0x8000, no input -> ENA_OUT every 2nd cycle, continuous null packets 47 1F FF 10 FF..., UNF_CNT +1 per 188 ticks.
REQ-036 Three back-to-back valid packets at full rate, RATE_INC=0x4000 -> output is exactly those 564 bytes in order, PSYNC_OUT on bytes 0/188/376, NULL_OUT=0.
REQ-037 Input faster than output until the FIFO holds 5 packets, then a 6th arrives -> OVF_PULSE once, 6th packet absent from output, first 5 intact.
REQ-038 SYNC_CHECK_EN: packet starting 0x48, then PSYNC_IN at byte 100 of the next -> DROP_CNT=2, neither packet output; a following good packet is output intact.
REQ-039 Assert RST at byte 90 of an output DATA packet -> all outputs 0 next cycle; after release, the first ENA_OUT byte is 0x47 with PSYNC_OUT=1.
